niosii_system_switch_debounce_ctrl: RTL and testbench



---
 rtl/niosii_system_switch_debounce_ctrl.sv | 129 ++++++++++++
 tb/tb_niosii_system_switch_debounce_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/niosii_system_switch_debounce_ctrl.sv
// Slide-switch debounce and edge-capture controller on an Avalon-MM slave port.
// Each switch bit is synchronized, filtered by its own debounce counter, and
// qualified edges are latched into a sticky capture register that drives a
// maskable level interrupt.
module niosii_system_switch_debounce_ctrl #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0]       ADDR_DATA = 2'd0;
    localparam logic [1:0]       ADDR_MASK = 2'd1;
    localparam logic [1:0]       ADDR_EDGE = 2'd2;
    localparam logic [1:0]       ADDR_CTRL = 2'd3;
    localparam int unsigned      CTRL_W    = 3;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Per-bit debounce decision for the current cycle
    typedef enum logic [1:0] {
        DB_MATCH  = 2'd0,
        DB_PEND   = 2'd1,
        DB_ACCEPT = 2'd2
    } db_act_e;

    logic [WIDTH-1:0]  sync1_q, sync2_q;
    logic [WIDTH-1:0]  stable_q, stable_d;
    logic [WIDTH-1:0]  prev_q;
    logic [WIDTH-1:0]  cap_q, cap_d;
    logic [WIDTH-1:0]  mask_q, mask_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  cnt_q [WIDTH];
    logic [CNT_W-1:0]  cnt_d [WIDTH];
    db_act_e           act   [WIDTH];

    logic              wr_c, rd_c, irq_d;
    logic [WIDTH-1:0]  rise_c, fall_c, sel_c, clr_c;
    logic [31:0]       rdata_d;
    logic              unused_wdata;

    // Upper write-data bits beyond the implemented register width are dropped
    assign unused_wdata = ^writedata;

    assign wr_c = chipselect & ~write_n;
    assign rd_c = chipselect & write_n;

    // Debounce next-state: classify each bit, then advance its counter/level
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = '0;
            act[i]   = DB_MATCH;
        end
        if (ctrl_q[0]) begin
            stable_d = sync2_q;
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (sync2_q[i] != stable_q[i]) begin
                    act[i] = (cnt_q[i] == CNT_MAX) ? DB_ACCEPT : DB_PEND;
                end
                case (act[i])
                    DB_PEND:   cnt_d[i]    = cnt_q[i] + CNT_W'(1);
                    DB_ACCEPT: stable_d[i] = sync2_q[i];
                    default:   ;
                endcase
            end
        end
    end

    // Edge selection, register writes, read mux and interrupt next values
    always_comb begin
        rise_c = stable_q & ~prev_q;
        fall_c = ~stable_q & prev_q;
        case (ctrl_q[2:1])
            2'b00:   sel_c = rise_c;
            2'b01:   sel_c = fall_c;
            default: sel_c = rise_c | fall_c;
        endcase
        clr_c  = (wr_c && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
        // A new edge in the same cycle as its write-clear keeps the bit set
        cap_d  = (cap_q & ~clr_c) | sel_c;
        mask_d = (wr_c && address == ADDR_MASK) ? writedata[WIDTH-1:0] : mask_q;
        ctrl_d = (wr_c && address == ADDR_CTRL) ? writedata[CTRL_W-1:0] : ctrl_q;
        irq_d  = |(cap_d & mask_d);
        case (address)
            ADDR_DATA: rdata_d = 32'(stable_q);
            ADDR_MASK: rdata_d = 32'(mask_q);
            ADDR_EDGE: rdata_d = 32'(cap_q);
            default:   rdata_d = 32'(ctrl_q);
        endcase
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            prev_q   <= '0;
            cap_q    <= '0;
            mask_q   <= '0;
            ctrl_q   <= '0;
            readdata <= '0;
            irq      <= 1'b0;
            for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= '0;
        end else begin
            sync1_q  <= in_port;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            prev_q   <= stable_q;
            cap_q    <= cap_d;
            mask_q   <= mask_d;
            ctrl_q   <= ctrl_d;
            irq      <= irq_d;
            if (rd_c) readdata <= rdata_d;
            for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= cnt_d[i];
        end
    end

endmodule

// File: tb/tb_niosii_system_switch_debounce_ctrl.sv
// Bench for the switch debounce controller: directed scenarios plus random
// traffic, compared against a window-based behavioural model.
module tb_niosii_system_switch_debounce_ctrl;

    localparam int unsigned W = 8;
    localparam int unsigned D = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_port = '0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;

    int checks = 0;
    int failures = 0;

    niosii_system_switch_debounce_ctrl #(
        .WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset), .in_port(in_port), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    // Reference model: a level is accepted once the last D synchronized
    // samples (taken with bypass off) all disagree with the current level.
    logic [7:0]  m_s1, m_s2, m_stable, m_prev, m_cap, m_mask;
    logic [2:0]  m_ctrl;
    logic [31:0] m_rd;
    logic        m_irq;
    logic [7:0]  h_val [D];
    bit          h_ok  [D];
    logic [7:0]  s, ns, rise, fall, sel, clr, ncap, nmask;
    logic [2:0]  nctrl;
    logic [31:0] nrd;
    bit          wr, rd, all_v;

    always @(posedge clk) begin
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_prev = '0; m_cap = '0;
            m_mask = '0; m_ctrl = '0; m_rd = '0; m_irq = 1'b0;
            for (int j = 0; j < int'(D); j++) begin h_val[j] = '0; h_ok[j] = 1'b0; end
        end else begin
            wr = chipselect && !write_n;
            rd = chipselect && write_n;
            s  = m_s2;
            for (int j = int'(D) - 1; j > 0; j--) begin
                h_val[j] = h_val[j-1];
                h_ok[j]  = h_ok[j-1];
            end
            h_val[0] = s;
            h_ok[0]  = !m_ctrl[0];
            ns = m_stable;
            if (m_ctrl[0]) ns = s;
            else begin
                for (int i = 0; i < int'(W); i++) begin
                    if (s[i] != m_stable[i]) begin
                        all_v = 1'b1;
                        for (int j = 0; j < int'(D); j++)
                            if (!h_ok[j] || h_val[j][i] != s[i]) all_v = 1'b0;
                        if (all_v) ns[i] = s[i];
                    end
                end
            end
            rise = m_stable & ~m_prev;
            fall = ~m_stable & m_prev;
            case (m_ctrl[2:1])
                2'b00:   sel = rise;
                2'b01:   sel = fall;
                default: sel = rise | fall;
            endcase
            clr   = (wr && address == 2'd2) ? writedata[7:0] : 8'h00;
            ncap  = (m_cap & ~clr) | sel;
            nmask = (wr && address == 2'd1) ? writedata[7:0] : m_mask;
            nctrl = (wr && address == 2'd3) ? writedata[2:0] : m_ctrl;
            nrd   = m_rd;
            if (rd) begin
                case (address)
                    2'd0:    nrd = {24'h0, m_stable};
                    2'd1:    nrd = {24'h0, m_mask};
                    2'd2:    nrd = {24'h0, m_cap};
                    default: nrd = {29'h0, m_ctrl};
                endcase
            end
            m_prev = m_stable; m_stable = ns; m_cap = ncap; m_mask = nmask;
            m_ctrl = nctrl; m_rd = nrd; m_irq = |(ncap & nmask);
            m_s2 = m_s1; m_s1 = in_port;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // One-cycle write, then return to reading DATA
    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        wait_cyc(1);
        write_n = 1'b1; address = 2'd0; writedata = '0;
    endtask

    task automatic test_reset;
        reset = 1'b1; chipselect = 1'b1; write_n = 1'b1; address = 2'd0;
        wait_cyc(2);
        checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL reset_rd: got %h want %h", readdata, 32'h0); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b want 0", irq); end
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            wait_cyc(1);
            checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL reset_reg%0d: got %h want 0", a, readdata); end
        end
        address = 2'd0;
    endtask

    task automatic test_step;
        in_port = 8'h00; wait_cyc(2);
        in_port = 8'hA5;
        for (int k = 1; k <= 12; k++) begin
            wait_cyc(1);
            checks++; if (readdata !== m_rd) begin failures++; $display("FAIL step_rd k=%0d: got %h want %h", k, readdata, m_rd); end
            checks++; if (irq !== m_irq) begin failures++; $display("FAIL step_irq k=%0d: got %b want %b", k, irq, m_irq); end
            if (k == 6) begin
                checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL step_early: got %h want 0", readdata); end
            end
            if (k == 7) begin
                checks++; if (readdata !== 32'hA5) begin failures++; $display("FAIL step_data: got %h want a5", readdata); end
                address = 2'd2;
            end
            if (k == 8) begin
                checks++; if (readdata !== 32'hA5) begin failures++; $display("FAIL step_edge: got %h want a5", readdata); end
            end
        end
        address = 2'd0;
    endtask

    task automatic test_glitch;
        in_port = 8'h00;
        do_write(2'd1, 32'h01);
        wait_cyc(8);
        do_write(2'd2, 32'hFF);
        in_port = 8'h01;
        for (int k = 1; k <= 12; k++) begin
            wait_cyc(1);
            checks++; if (readdata !== m_rd) begin failures++; $display("FAIL glitch_rd k=%0d: got %h want %h", k, readdata, m_rd); end
            checks++; if (readdata[0] !== 1'b0 || irq !== 1'b0) begin failures++; $display("FAIL glitch_reject k=%0d: got data0=%b irq=%b want 0/0", k, readdata[0], irq); end
            if (k == 3) in_port = 8'h00;
        end
        address = 2'd2; wait_cyc(1);
        checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL glitch_edge: got %h want 0", readdata); end
        address = 2'd0; in_port = 8'h01;
        for (int k = 1; k <= 10; k++) begin
            wait_cyc(1);
            checks++; if (readdata !== m_rd || irq !== m_irq) begin failures++; $display("FAIL hold_rd k=%0d: got %h/%b want %h/%b", k, readdata, irq, m_rd, m_irq); end
        end
        address = 2'd2; wait_cyc(1);
        checks++; if (readdata !== 32'h01 || irq !== 1'b1) begin failures++; $display("FAIL hold_accept: got %h/%b want 01/1", readdata, irq); end
        address = 2'd0;
    endtask

    task automatic test_fall_irq;
        do_write(2'd3, 32'h2);
        do_write(2'd1, 32'h01);
        do_write(2'd2, 32'hFF);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL fall_pre_irq: got %b want 0", irq); end
        in_port = 8'h00;
        for (int k = 1; k <= 10; k++) begin
            wait_cyc(1);
            checks++; if (readdata !== m_rd || irq !== m_irq) begin failures++; $display("FAIL fall_rd k=%0d: got %h/%b want %h/%b", k, readdata, irq, m_rd, m_irq); end
        end
        address = 2'd2; wait_cyc(1);
        checks++; if (readdata !== 32'h01 || irq !== 1'b1) begin failures++; $display("FAIL fall_edge: got %h/%b want 01/1", readdata, irq); end
        do_write(2'd2, 32'h01);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL fall_clear_irq: got %b want 0", irq); end
    endtask

    task automatic test_collision;
        do_write(2'd3, 32'h4);
        do_write(2'd1, 32'h08);
        do_write(2'd2, 32'hFF);
        in_port = 8'h08;
        wait_cyc(6);
        chipselect = 1'b1; write_n = 1'b0; address = 2'd2; writedata = 32'h08;
        wait_cyc(1);
        write_n = 1'b1; writedata = '0;
        checks++; if (irq !== 1'b1 || irq !== m_irq) begin failures++; $display("FAIL coll_irq: got %b want 1", irq); end
        wait_cyc(1);
        checks++; if (readdata !== 32'h08 || readdata !== m_rd) begin failures++; $display("FAIL coll_edge: got %h want 08", readdata); end
        address = 2'd0;
    endtask

    task automatic test_bypass;
        do_write(2'd2, 32'hFF);
        do_write(2'd3, 32'h5);
        for (int t = 0; t < 6; t++) begin
            in_port[7] = ~in_port[7];
            chipselect = 1'b1; write_n = 1'b0; address = 2'd2; writedata = 32'h80;
            for (int k = 1; k <= 5; k++) begin
                wait_cyc(1);
                if (k == 1) begin write_n = 1'b1; address = 2'd0; writedata = '0; end
                checks++; if (readdata !== m_rd || irq !== m_irq) begin failures++; $display("FAIL byp_rd t=%0d k=%0d: got %h/%b want %h/%b", t, k, readdata, irq, m_rd, m_irq); end
                if (k == 3) begin
                    checks++; if (readdata[7] === in_port[7]) begin failures++; $display("FAIL byp_early t=%0d: got %b want %b", t, readdata[7], ~in_port[7]); end
                end
                if (k == 4) begin
                    checks++; if (readdata[7] !== in_port[7]) begin failures++; $display("FAIL byp_lag t=%0d: got %b want %b", t, readdata[7], in_port[7]); end
                    address = 2'd2;
                end
                if (k == 5) begin
                    checks++; if (readdata[7] !== 1'b1) begin failures++; $display("FAIL byp_edge t=%0d: got %b want 1", t, readdata[7]); end
                end
            end
        end
        do_write(2'd3, 32'h0);
    endtask

    task automatic test_random;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(5) == 0) in_port = 8'($urandom);
            chipselect = 1'b1;
            address = 2'($urandom_range(3));
            write_n = ($urandom_range(7) != 0);
            writedata = $urandom;
            wait_cyc(1);
            checks++; if (readdata !== m_rd || irq !== m_irq) begin failures++; $display("FAIL rand c=%0d: got %h/%b want %h/%b", c, readdata, irq, m_rd, m_irq); end
        end
        write_n = 1'b1; address = 2'd0;
    endtask

    task automatic test_reset_mid;
        in_port = 8'h00; reset = 1'b1; wait_cyc(2); reset = 1'b0;
        do_write(2'd1, 32'hFF);
        do_write(2'd3, 32'h5);
        in_port = 8'hFF;
        wait_cyc(6);
        address = 2'd2; wait_cyc(1);
        checks++; if (readdata !== 32'hFF || irq !== 1'b1) begin failures++; $display("FAIL rm_setup: got %h/%b want ff/1", readdata, irq); end
        do_write(2'd3, 32'h4);
        in_port = 8'h00;
        wait_cyc(4);
        reset = 1'b1; chipselect = 1'b1; write_n = 1'b0; address = 2'd1; writedata = 32'hFF;
        wait_cyc(1);
        checks++; if (readdata !== 32'h0 || irq !== 1'b0) begin failures++; $display("FAIL rm_reset: got %h/%b want 0/0", readdata, irq); end
        reset = 1'b0; write_n = 1'b1; writedata = '0;
        for (int a = 0; a < 4; a++) begin
            address = 2'(a);
            wait_cyc(1);
            checks++; if (readdata !== 32'h0) begin failures++; $display("FAIL rm_reg%0d: got %h want 0", a, readdata); end
        end
        address = 2'd0;
        for (int k = 0; k < 8; k++) begin
            wait_cyc(1);
            checks++; if (readdata !== m_rd || irq !== m_irq || readdata !== 32'h0) begin failures++; $display("FAIL rm_after k=%0d: got %h/%b want 0/0", k, readdata, irq); end
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_glitch();
        test_fall_irq();
        test_collision();
        test_bypass();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
